crossbar_2x2_scheduler: RTL and testbench
=========================================

# crossbar_2x2_scheduler

Input-queuing and scheduling stage that sits directly upstream of the 2x2 4-bit crossbar. It buffers destination-tagged nibbles arriving on two ports and resolves output contention with round-robin priority. Each cycle it drives the crossbar's `in1`, `in2` and `control` inputs from registers, plus a valid flag per crossbar output. Crossbar semantics are fixed: `control`=0 gives out1=in1, out2=in2; `control`=1 gives out1=in2, out2=in1.

## Interface
- `WIDTH`, 4, data width per flit.
- `DEPTH`, 4, entries per input FIFO; power of two, ≥2.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `in1_data`  in  WIDTH  port-1 flit.
- `in1_dest`  in  1  port-1 destination: 0 = out1, 1 = out2.
- `in1_valid`  in  1  port-1 offer.
- `in1_ready`  out  1  port-1 FIFO not full.
- `in2_data`, `in2_dest`, `in2_valid`, `in2_ready`: same as port 1, for port 2.
- `xb_in1`  out  WIDTH  registered to crossbar `in1`.
- `xb_in2`  out  WIDTH  registered to crossbar `in2`.
- `xb_control`  out  1  registered to crossbar `control`.
- `out1_valid`  out  1  crossbar out1 carries a flit this cycle.
- `out2_valid`  out  1  crossbar out2 carries a flit this cycle.

## Operation
- Push: on a rising edge where `inN_valid` and `inN_ready` are both 1, the flit `{dest,data}` is written to FIFO N. `inN_ready` = !full and is forced to 0 while `rst_n`=0.
- The scheduler evaluates both FIFO heads every cycle. Results are registered at the next edge.
- Both heads valid, different destinations: pop both; no conflict.
  - `xb_control` = head1.dest (0 = straight, 1 = cross).
  - Both out valids = 1.
- Both heads valid, same destination: conflict.
  - Winner is port 1 if `prio`=0, otherwise port 2. Pop the winner only.
  - `prio` toggles to favour the loser.
  - Winner's data goes on its own `xb_inN`; the other `xb_in` lane = 0.
  - `xb_control` = winner dest XOR (winner==port2).
  - Only the destination's valid = 1.
- One head valid: pop it with the same routing as a conflict winner. `prio` is unchanged.
- No head valid: both valids = 0, `xb_in1`/`xb_in2` = 0, `xb_control` holds its last value.
- `prio` changes only on conflict cycles.
- Idle lanes always carry 0 data.
- FIFO: count width $clog2(DEPTH)+1, pointers wrap modulo DEPTH.
  - Push and pop in the same cycle leave count unchanged.
  - Push into a full FIFO is impossible because ready=0.
  - Pop of an empty FIFO never occurs.
  - No bypass: a flit pushed into an empty FIFO is first eligible for scheduling the cycle after the push.

## Timing
- Reset (edge with `rst_n`=0):
  - FIFOs empty, `prio`=0.
  - `xb_in1`=`xb_in2`=0, `xb_control`=0, `out1_valid`=`out2_valid`=0.
  - `inN_ready`=0 during reset, 1 on the first cycle after release.
- Reset asserted mid-operation discards all queued flits. Outputs take their reset values at that edge.
- Latency: a flit accepted at edge k appears on `xb_in*` with its valid high after edge k+1, if it wins.
- Throughput: up to 2 flits/cycle without conflicts, 1 flit/cycle under persistent conflict.
- Fairness: under persistent conflict, ports alternate strictly.

## Structure
- Shared header `crossbar_defs.vh`: `WIDTH`, `DEPTH` defaults, `DEST_OUT1`=0, `DEST_OUT2`=1, `CTRL_STRAIGHT`=0, `CTRL_CROSS`=1.
- One sub-module, `sync_fifo`:
  - WIDTH+1 bits wide, DEPTH entries.
  - push/pop/full/empty/head interface.
  - Instantiated twice.
- Scheduler and output registers live in the top level.
- Bench instantiates this block feeding `Crossbar_2x2_4bit` and checks the crossbar outputs.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with both valids high → no push, all outputs 0, readys 0. After release, readys = 1.
- No conflict:
  - Push in1=4'h3 dest 1 and in2=4'hA dest 0 at edge k.
  - After edge k+1: `xb_control`=1, out1=4'hA, out2=4'h3, both valids 1.
- Conflict round-robin:
  - Every cycle, push in1=4'h1 and in2=4'h2, both dest 0.
  - out1 alternates 1,2,1,2… with `out2_valid`=0 throughout.
  - `prio` toggles each cycle.
- Single port cross:
  - Push only in2=4'hC dest 1.
  - Result: `xb_control`=0, out2=4'hC, `out2_valid`=1, `out1_valid`=0, `xb_in1`=0.
- Full/backpressure:
  - Hold in1 flits dest 0 and in2 flits dest 0 to force conflicts.
  - Fill both FIFOs to DEPTH; `in1_ready` falls and no extra push is accepted.
  - Drain to verify order 0..n preserved, including pointer wrap.
- Reset mid-stream: with 3 flits queued, assert `rst_n` one cycle → queues empty, outputs 0, first post-reset flit uses `prio`=0.

Source files
------------

// File: rtl/crossbar_2x2_scheduler_pkg.sv
// Shared definitions for the 2x2 crossbar input scheduler.
// Provides default sizes, destination/control encodings and the grant type
// the scheduler uses to describe which FIFO heads it serves in a cycle.
package crossbar_2x2_scheduler_pkg;

  localparam int unsigned DefWidth = 4;
  localparam int unsigned DefDepth = 4;

  localparam logic DestOut1     = 1'b0;
  localparam logic DestOut2     = 1'b1;
  localparam logic CtrlStraight = 1'b0;
  localparam logic CtrlCross    = 1'b1;

  typedef enum logic [1:0] {
    GrantNone,
    GrantPort1,
    GrantPort2,
    GrantBoth
  } grant_e;

endpackage

// File: rtl/crossbar_2x2_scheduler_sync_fifo.sv
// Synchronous FIFO holding destination-tagged flits for one input port.
// Ports:
//   clk_i, rst_ni      clock, synchronous active-low reset
//   push_i, data_i     write a flit (caller guarantees not full)
//   pop_i              discard the head (caller guarantees not empty)
//   full_o, empty_o    occupancy flags
//   head_o             oldest stored flit
module crossbar_2x2_scheduler_sync_fifo #(
  parameter int unsigned Width = 5,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [Width-1:0] head_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;

  // Depth is a power of two, so the pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PtrW'(push_i);
    rd_ptr_d = rd_ptr_q + PtrW'(pop_i);
    count_d  = count_q + CntW'(push_i) - CntW'(pop_i);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy alone defines what is valid.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/crossbar_2x2_scheduler.sv
// Input queuing and round-robin scheduling in front of a 2x2 crossbar.
// Each port buffers {dest,data} flits; every cycle the two FIFO heads are
// scheduled and the crossbar inputs, control and per-output valids are
// driven from registers.
// Ports:
//   clk, rst_n                         clock, synchronous active-low reset
//   inN_data/dest/valid, inN_ready     per-port flit offer with backpressure
//   xb_in1, xb_in2, xb_control         registered crossbar drive
//   out1_valid, out2_valid             crossbar output carries a flit
module crossbar_2x2_scheduler
  import crossbar_2x2_scheduler_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned DEPTH = DefDepth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in1_data,
  input  logic             in1_dest,
  input  logic             in1_valid,
  output logic             in1_ready,
  input  logic [WIDTH-1:0] in2_data,
  input  logic             in2_dest,
  input  logic             in2_valid,
  output logic             in2_ready,
  output logic [WIDTH-1:0] xb_in1,
  output logic [WIDTH-1:0] xb_in2,
  output logic             xb_control,
  output logic             out1_valid,
  output logic             out2_valid
);

  logic             full1, full2, empty1, empty2;
  logic             push1, push2, pop1, pop2;
  logic [WIDTH:0]   head1, head2;
  logic             head1_dest, head2_dest;
  logic [WIDTH-1:0] head1_data, head2_data;

  logic             prio_q, prio_d;
  logic [WIDTH-1:0] xb_in1_q, xb_in1_d;
  logic [WIDTH-1:0] xb_in2_q, xb_in2_d;
  logic             ctrl_q, ctrl_d;
  logic             out1_valid_q, out1_valid_d;
  logic             out2_valid_q, out2_valid_d;
  grant_e           grant;

  assign in1_ready = rst_n & ~full1;
  assign in2_ready = rst_n & ~full2;
  assign push1     = in1_valid & in1_ready;
  assign push2     = in2_valid & in2_ready;

  crossbar_2x2_scheduler_sync_fifo #(
    .Width (WIDTH + 1),
    .Depth (DEPTH)
  ) u_fifo1 (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (push1),
    .data_i  ({in1_dest, in1_data}),
    .pop_i   (pop1),
    .full_o  (full1),
    .empty_o (empty1),
    .head_o  (head1)
  );

  crossbar_2x2_scheduler_sync_fifo #(
    .Width (WIDTH + 1),
    .Depth (DEPTH)
  ) u_fifo2 (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (push2),
    .data_i  ({in2_dest, in2_data}),
    .pop_i   (pop2),
    .full_o  (full2),
    .empty_o (empty2),
    .head_o  (head2)
  );

  assign head1_dest = head1[WIDTH];
  assign head1_data = head1[WIDTH-1:0];
  assign head2_dest = head2[WIDTH];
  assign head2_data = head2[WIDTH-1:0];

  // Arbitration: priority only moves on a genuine same-destination conflict.
  always_comb begin
    grant  = GrantNone;
    prio_d = prio_q;
    if (!empty1 && !empty2) begin
      if (head1_dest != head2_dest) begin
        grant = GrantBoth;
      end else begin
        grant  = prio_q ? GrantPort2 : GrantPort1;
        prio_d = ~prio_q;
      end
    end else if (!empty1) begin
      grant = GrantPort1;
    end else if (!empty2) begin
      grant = GrantPort2;
    end
  end

  // Routing: a flit always sits on its own port's lane; control steers it.
  always_comb begin
    pop1         = 1'b0;
    pop2         = 1'b0;
    xb_in1_d     = '0;
    xb_in2_d     = '0;
    ctrl_d       = ctrl_q;
    out1_valid_d = 1'b0;
    out2_valid_d = 1'b0;
    unique case (grant)
      GrantBoth: begin
        pop1         = 1'b1;
        pop2         = 1'b1;
        xb_in1_d     = head1_data;
        xb_in2_d     = head2_data;
        ctrl_d       = (head1_dest == DestOut2) ? CtrlCross : CtrlStraight;
        out1_valid_d = 1'b1;
        out2_valid_d = 1'b1;
      end
      GrantPort1: begin
        pop1         = 1'b1;
        xb_in1_d     = head1_data;
        ctrl_d       = (head1_dest == DestOut2) ? CtrlCross : CtrlStraight;
        out1_valid_d = (head1_dest == DestOut1);
        out2_valid_d = (head1_dest == DestOut2);
      end
      GrantPort2: begin
        pop2         = 1'b1;
        xb_in2_d     = head2_data;
        // Port 2 reaches out2 straight and out1 only when crossed.
        ctrl_d       = (head2_dest == DestOut1) ? CtrlCross : CtrlStraight;
        out1_valid_d = (head2_dest == DestOut1);
        out2_valid_d = (head2_dest == DestOut2);
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio_q       <= 1'b0;
      xb_in1_q     <= '0;
      xb_in2_q     <= '0;
      ctrl_q       <= CtrlStraight;
      out1_valid_q <= 1'b0;
      out2_valid_q <= 1'b0;
    end else begin
      prio_q       <= prio_d;
      xb_in1_q     <= xb_in1_d;
      xb_in2_q     <= xb_in2_d;
      ctrl_q       <= ctrl_d;
      out1_valid_q <= out1_valid_d;
      out2_valid_q <= out2_valid_d;
    end
  end

  assign xb_in1     = xb_in1_q;
  assign xb_in2     = xb_in2_q;
  assign xb_control = ctrl_q;
  assign out1_valid = out1_valid_q;
  assign out2_valid = out2_valid_q;

endmodule

// File: tb/tb_crossbar_2x2_scheduler.sv
module tb_crossbar_2x2_scheduler;

  localparam int unsigned W = 4;
  localparam int unsigned D = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] in1_data, in2_data;
  logic         in1_dest, in2_dest, in1_valid, in2_valid;
  logic         in1_ready, in2_ready;
  logic [W-1:0] xb_in1, xb_in2;
  logic         xb_control, out1_valid, out2_valid;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  crossbar_2x2_scheduler #(
    .WIDTH (W),
    .DEPTH (D)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in1_data   (in1_data),
    .in1_dest   (in1_dest),
    .in1_valid  (in1_valid),
    .in1_ready  (in1_ready),
    .in2_data   (in2_data),
    .in2_dest   (in2_dest),
    .in2_valid  (in2_valid),
    .in2_ready  (in2_ready),
    .xb_in1     (xb_in1),
    .xb_in2     (xb_in2),
    .xb_control (xb_control),
    .out1_valid (out1_valid),
    .out2_valid (out2_valid)
  );

  // Downstream crossbar behaviour.
  function automatic logic [W-1:0] xbar_out(input bit port2, input logic ctrl,
                                            input logic [W-1:0] a, input logic [W-1:0] b);
    if (!port2) return ctrl ? b : a;
    return ctrl ? a : b;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per-port queues of {dest,data}, a fairness bit, and the
  // flit expected on each crossbar output after the edge.
  logic [W:0]   q1[$];
  logic [W:0]   q2[$];
  bit           m_prio;
  logic [W-1:0] m_lane1, m_lane2, m_out1, m_out2;
  logic         m_ctrl, m_v1, m_v2;

  task automatic model_edge(input bit r, input bit acc1, input logic [W:0] f1,
                            input bit acc2, input logic [W:0] f2);
    bit s1, s2;
    logic [W:0] h1, h2;
    if (!r) begin
      q1.delete();
      q2.delete();
      m_prio = 0;
      {m_lane1, m_lane2, m_out1, m_out2} = '0;
      {m_ctrl, m_v1, m_v2} = '0;
      return;
    end
    s1 = 0;
    s2 = 0;
    h1 = '0;
    h2 = '0;
    if (q1.size() > 0) h1 = q1[0];
    if (q2.size() > 0) h2 = q2[0];
    if (q1.size() > 0 && q2.size() > 0) begin
      if (h1[W] != h2[W]) begin
        s1 = 1;
        s2 = 1;
      end else begin
        if (!m_prio) s1 = 1;
        else s2 = 1;
        m_prio = !m_prio;
      end
    end else begin
      s1 = (q1.size() > 0);
      s2 = (q2.size() > 0);
    end
    m_lane1 = s1 ? h1[W-1:0] : '0;
    m_lane2 = s2 ? h2[W-1:0] : '0;
    m_out1 = '0;
    m_out2 = '0;
    m_v1 = 0;
    m_v2 = 0;
    if (s1) begin
      if (h1[W]) begin m_v2 = 1; m_out2 = h1[W-1:0]; end
      else begin m_v1 = 1; m_out1 = h1[W-1:0]; end
    end
    if (s2) begin
      if (h2[W]) begin m_v2 = 1; m_out2 = h2[W-1:0]; end
      else begin m_v1 = 1; m_out1 = h2[W-1:0]; end
    end
    // Crossing is needed when port 1 goes to out2 or port 2 goes to out1.
    if (s1 || s2) m_ctrl = (s1 && h1[W]) || (s2 && !h2[W]);
    if (s1) void'(q1.pop_front());
    if (s2) void'(q2.pop_front());
    if (acc1) q1.push_back(f1);
    if (acc2) q2.push_back(f2);
  endtask

  task automatic step(input bit r, input bit v1, input bit d1, input logic [W-1:0] x1,
                      input bit v2, input bit d2, input logic [W-1:0] x2);
    bit mr1, mr2;
    rst_n     = r;
    in1_valid = v1;
    in1_dest  = d1;
    in1_data  = x1;
    in2_valid = v2;
    in2_dest  = d2;
    in2_data  = x2;
    #1;
    mr1 = r && (q1.size() < D);
    mr2 = r && (q2.size() < D);
    check("in1_ready", 32'(in1_ready), 32'(mr1));
    check("in2_ready", 32'(in2_ready), 32'(mr2));
    model_edge(r, v1 && mr1, {d1, x1}, v2 && mr2, {d2, x2});
    @(posedge clk);
    #1;
    check("xb_in1", 32'(xb_in1), 32'(m_lane1));
    check("xb_in2", 32'(xb_in2), 32'(m_lane2));
    check("xb_control", 32'(xb_control), 32'(m_ctrl));
    check("out1_valid", 32'(out1_valid), 32'(m_v1));
    check("out2_valid", 32'(out2_valid), 32'(m_v2));
    check("xbar_out1", 32'(xbar_out(0, xb_control, xb_in1, xb_in2)), 32'(m_out1));
    check("xbar_out2", 32'(xbar_out(1, xb_control, xb_in1, xb_in2)), 32'(m_out2));
  endtask

  typedef struct {
    bit           r;
    bit           v1;
    bit           d1;
    logic [W-1:0] x1;
    bit           v2;
    bit           d2;
    logic [W-1:0] x2;
    bit           o1v;
    logic [W-1:0] o1;
    bit           o2v;
    logic [W-1:0] o2;
    bit           c;
  } vec_t;

  function automatic vec_t mk(bit r, bit v1, bit d1, logic [W-1:0] x1, bit v2, bit d2,
                              logic [W-1:0] x2, bit o1v, logic [W-1:0] o1, bit o2v,
                              logic [W-1:0] o2, bit c);
    vec_t v;
    v.r = r; v.v1 = v1; v.d1 = d1; v.x1 = x1; v.v2 = v2; v.d2 = d2; v.x2 = x2;
    v.o1v = o1v; v.o1 = o1; v.o2v = o2v; v.o2 = o2; v.c = c;
    return v;
  endfunction

  vec_t tbl[12];

  initial begin
    int n1, n2, full_seen;
    tbl[0]  = mk(0, 1, 0, 4'h5, 1, 1, 4'h6, 0, 4'h0, 0, 4'h0, 0);
    tbl[1]  = mk(0, 1, 0, 4'h5, 1, 1, 4'h6, 0, 4'h0, 0, 4'h0, 0);
    tbl[2]  = mk(1, 0, 0, 4'h0, 0, 0, 4'h0, 0, 4'h0, 0, 4'h0, 0);
    tbl[3]  = mk(1, 1, 1, 4'h3, 1, 0, 4'hA, 0, 4'h0, 0, 4'h0, 0);
    tbl[4]  = mk(1, 0, 0, 4'h0, 0, 0, 4'h0, 1, 4'hA, 1, 4'h3, 1);
    tbl[5]  = mk(1, 0, 0, 4'h0, 1, 1, 4'hC, 0, 4'h0, 0, 4'h0, 1);
    tbl[6]  = mk(1, 0, 0, 4'h0, 0, 0, 4'h0, 0, 4'h0, 1, 4'hC, 0);
    tbl[7]  = mk(1, 1, 0, 4'h1, 1, 0, 4'h2, 0, 4'h0, 0, 4'h0, 0);
    tbl[8]  = mk(1, 1, 0, 4'h1, 1, 0, 4'h2, 1, 4'h1, 0, 4'h0, 0);
    tbl[9]  = mk(1, 1, 0, 4'h1, 1, 0, 4'h2, 1, 4'h2, 0, 4'h0, 1);
    tbl[10] = mk(1, 1, 0, 4'h1, 1, 0, 4'h2, 1, 4'h1, 0, 4'h0, 0);
    tbl[11] = mk(1, 1, 0, 4'h1, 1, 0, 4'h2, 1, 4'h2, 0, 4'h0, 1);

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].r, tbl[i].v1, tbl[i].d1, tbl[i].x1, tbl[i].v2, tbl[i].d2, tbl[i].x2);
      check($sformatf("vec%0d_out1", i), 32'(xbar_out(0, xb_control, xb_in1, xb_in2)),
            32'(tbl[i].o1));
      check($sformatf("vec%0d_out2", i), 32'(xbar_out(1, xb_control, xb_in1, xb_in2)),
            32'(tbl[i].o2));
      check($sformatf("vec%0d_v1", i), 32'(out1_valid), 32'(tbl[i].o1v));
      check($sformatf("vec%0d_v2", i), 32'(out2_valid), 32'(tbl[i].o2v));
      check($sformatf("vec%0d_ctrl", i), 32'(xb_control), 32'(tbl[i].c));
    end

    // Backpressure: persistent conflicts on out1 while pushing every cycle.
    step(0, 0, 0, 4'h0, 0, 0, 4'h0);
    n1 = 0;
    n2 = 8;
    full_seen = 0;
    for (int i = 0; i < 14; i++) begin
      bit a1, a2;
      a1 = (q1.size() < D);
      a2 = (q2.size() < D);
      if (q1.size() == D) begin
        full_seen++;
        check("full_in1_ready", 32'(in1_ready), 32'(0));
      end
      step(1, 1, 0, 4'(n1), 1, 0, 4'(n2));
      if (a1) n1++;
      if (a2) n2++;
    end
    check("full_reached", 32'(full_seen != 0), 32'(1));
    for (int i = 0; i < 12; i++) step(1, 0, 0, 4'h0, 0, 0, 4'h0);
    check("drained_v1", 32'(out1_valid), 32'(0));

    // Reset mid-stream discards queued flits and re-arms priority to port 1.
    for (int i = 0; i < 3; i++) step(1, 1, 0, 4'(i + 1), 1, 0, 4'(i + 9));
    step(0, 1, 0, 4'hF, 1, 0, 4'hF);
    check("midrst_v1", 32'(out1_valid), 32'(0));
    check("midrst_lane1", 32'(xb_in1), 32'(0));
    step(1, 0, 0, 4'h0, 0, 0, 4'h0);
    check("postrst_idle", 32'(out1_valid | out2_valid), 32'(0));
    step(1, 1, 0, 4'h7, 1, 0, 4'h9);
    step(1, 0, 0, 4'h0, 0, 0, 4'h0);
    check("postrst_winner", 32'(xbar_out(0, xb_control, xb_in1, xb_in2)), 32'(4'h7));
    step(1, 0, 0, 4'h0, 0, 0, 4'h0);
    check("postrst_loser", 32'(xbar_out(0, xb_control, xb_in1, xb_in2)), 32'(4'h9));

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 39) != 0,
           $urandom_range(0, 3) != 0, 1'($urandom), 4'($urandom),
           $urandom_range(0, 3) != 0, 1'($urandom), 4'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
